register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry x 32-bit integer register file (RV32I x0..x31) that sources operands a and b for the ALU in the execute path.
- Two combinational read ports and one synchronous write port; the write port takes the ALU result or other writeback data.
- x0 is hardwired to zero.
- Optional write-to-read bypass lets an operand written in a cycle be read by the ALU in that same cycle.

Parameters:
- N, 32, data width. Only 32 is supported; it is used as a constant.
- ADDR_W, 5, register address width. The file has 2**ADDR_W = 32 entries.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port; when 0 reads return the stored value only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_ena  input  1  write enable.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  N  data to write (ALU result or writeback mux output).
- rd_addr0  input  ADDR_W  read port 0 index (rs1).
- rd_data0  output  N  read port 0 data; feeds ALU operand a.
- rd_addr1  input  ADDR_W  read port 1 index (rs2).
- rd_data1  output  N  read port 1 data; feeds ALU operand b.

Behaviour:
- Storage: 31 physical N-bit registers x1..x31. x0 has no storage and always reads 32'h0.
- Reset:
  - rst=1 at a rising edge clears x1..x31 to 0 at that edge.
  - rst has priority over wr_ena in the same cycle; the write is dropped.
  - Reset mid-stream discards any in-flight write.
  - After reset, every read returns 0.
- Write:
  - On a rising edge with rst=0 and wr_ena=1, register[wr_addr] <= wr_data.
  - A write to x0 is ignored; no state changes.
  - wr_ena=0 leaves all registers unchanged.
  - Write decode is one-hot over 32 indices; exactly one register enable is asserted per write.
- Read:
  - Purely combinational from rd_addrN; zero latency.
  - rd_dataN = 0 when rd_addrN == 0.
  - Otherwise rd_dataN = register[rd_addrN], except when the bypass rule below applies.
  - Both ports are independent; rd_addr0 == rd_addr1 returns identical data on both.
- Bypass (BYPASS=1):
  - If wr_ena=1, rst=0, wr_addr != 0 and wr_addr == rd_addrN, then rd_dataN = wr_data in the same cycle, before the edge.
  - This applies to each port independently.
  - No bypass when rst=1 or wr_addr == 0.
- Bypass (BYPASS=0): reads show the old value until the edge, then the new value.
- Outputs carry no registered state; they are purely combinational functions of inputs and stored registers. There are no X states after reset.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data0 and rd_data1 = 32'h0.
- Write 32'hDEADBEEF to x5, then in the next cycle rd_addr0=5, rd_addr1=5 -> both = 32'hDEADBEEF. Other addresses remain 0.
- Write 32'hFFFFFFFF to x0, then read x0 -> 32'h0. No other register changes.
- BYPASS=1: wr_ena=1, wr_addr=7, wr_data=32'h12345678, rd_addr1=7 in the same cycle -> rd_data1 = 32'h12345678 before the edge. BYPASS=0 -> old value (0) before the edge, 32'h12345678 after.
- rst=1 and wr_ena=1, wr_addr=3, wr_data=32'hA5A5A5A5 in the same cycle (x3 preloaded with 32'h1) -> x3 reads 0 after the edge, with no bypass during the cycle.
- Write x31 = 32'h80000000 and x1 = 32'h00000001, then rd_addr0=31, rd_addr1=1 driving the ALU ADD -> rd_data0 = 32'h80000000, rd_data1 = 32'h00000001, ALU result = 32'h80000001.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32x32 RV32I integer register file, two async read ports, one sync write port, optional write-to-read bypass
module register_file #(
   parameter int N      = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_ena,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [N-1:0]      wr_data,
   input  logic [ADDR_W-1:0] rd_addr0,
   output logic [N-1:0]      rd_data0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [N-1:0]      rd_data1
);
   localparam int DEPTH = 2**ADDR_W;
   logic [N-1:0]     regs_q [1:DEPTH-1];
   logic [N-1:0]     regs_d [1:DEPTH-1];
   logic [N-1:0]     view   [DEPTH];
   logic [DEPTH-1:0] wr_sel;
   logic             wr_live;
   logic             byp0;
   logic             byp1;
   always_comb begin
      wr_live = wr_ena && !rst && wr_addr != '0;
      wr_sel = '0;
      wr_sel[wr_addr] = wr_live;
      view[0] = '0;
      for (int i = 1; i < DEPTH; i++) begin
         regs_d[i] = rst ? '0 : (wr_sel[i] ? wr_data : regs_q[i]);
         view[i] = regs_q[i];
      end
      byp0 = BYPASS != 0 && wr_live && wr_addr == rd_addr0;
      byp1 = BYPASS != 0 && wr_live && wr_addr == rd_addr1;
      rd_data0 = byp0 ? wr_data : view[rd_addr0];
      rd_data1 = byp1 ? wr_data : view[rd_addr1];
   end
   always_ff @(posedge clk) regs_q <= regs_d;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file with bypass on (dut) and off (dut_nb)
module tb_register_file;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_ena = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [4:0]  rd_addr0 = '0;
   logic [4:0]  rd_addr1 = '0;
   logic [31:0] rd_data0, rd_data1, nb_data0, nb_data1;
   int tests = 0;
   int errors = 0;

   register_file #(.N(32), .ADDR_W(5), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1));
   register_file #(.N(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr0(rd_addr0), .rd_data0(nb_data0), .rd_addr1(rd_addr1), .rd_data1(nb_data1));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      wr_ena = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_ena = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
         #1;
         tests++;
         if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0 || nb_data0 !== 32'h0 || nb_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_read addr=%0d got %h/%h nb %h/%h want 0", i, rd_data0, rd_data1, nb_data0, nb_data1);
         end
      end
   endtask

   task automatic test_write_read();
      write(5'd5, 32'hDEADBEEF);
      rd_addr0 = 5'd5; rd_addr1 = 5'd5;
      #1;
      tests++;
      if (rd_data0 !== 32'hDEADBEEF || rd_data1 !== 32'hDEADBEEF || nb_data0 !== 32'hDEADBEEF || nb_data1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_x5 got %h/%h nb %h/%h want deadbeef", rd_data0, rd_data1, nb_data0, nb_data1);
      end
      rd_addr0 = 5'd4; rd_addr1 = 5'd6;
      #1;
      tests++;
      if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
         errors++;
         $display("FAIL neighbours_x4_x6 got %h/%h want 0", rd_data0, rd_data1);
      end
   endtask

   task automatic test_x0();
      wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      rd_addr0 = 5'd0; rd_addr1 = 5'd0;
      #1;
      tests++;
      if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_no_bypass got %h/%h want 0", rd_data0, rd_data1);
      end
      tick();
      wr_ena = 1'b0;
      #1;
      tests++;
      if (rd_data0 !== 32'h0 || nb_data0 !== 32'h0) begin
         errors++;
         $display("FAIL x0_after_write got %h nb %h want 0", rd_data0, nb_data0);
      end
      rd_addr0 = 5'd5; rd_addr1 = 5'd1;
      #1;
      tests++;
      if (rd_data0 !== 32'hDEADBEEF || rd_data1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_side_effect got x5=%h x1=%h want deadbeef/0", rd_data0, rd_data1);
      end
   endtask

   task automatic test_bypass();
      wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
      rd_addr0 = 5'd6; rd_addr1 = 5'd7;
      #1;
      tests++;
      if (rd_data1 !== 32'h12345678 || rd_data0 !== 32'h0) begin
         errors++;
         $display("FAIL bypass_on got p0=%h p1=%h want 0/12345678", rd_data0, rd_data1);
      end
      tests++;
      if (nb_data1 !== 32'h0) begin
         errors++;
         $display("FAIL bypass_off_before got %h want 0", nb_data1);
      end
      rd_addr0 = 5'd7;
      #1;
      tests++;
      if (rd_data0 !== 32'h12345678) begin
         errors++;
         $display("FAIL bypass_port0 got %h want 12345678", rd_data0);
      end
      tick();
      wr_ena = 1'b0;
      #1;
      tests++;
      if (rd_data1 !== 32'h12345678 || nb_data1 !== 32'h12345678) begin
         errors++;
         $display("FAIL bypass_after_edge got %h nb %h want 12345678", rd_data1, nb_data1);
      end
   endtask

   task automatic test_reset_priority();
      write(5'd3, 32'h1);
      rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
      rd_addr0 = 5'd3; rd_addr1 = 5'd3;
      #1;
      tests++;
      if (rd_data0 !== 32'h1 || nb_data0 !== 32'h1) begin
         errors++;
         $display("FAIL rst_no_bypass got %h nb %h want 00000001", rd_data0, nb_data0);
      end
      tick();
      rst = 1'b0; wr_ena = 1'b0;
      #1;
      tests++;
      if (rd_data0 !== 32'h0 || nb_data1 !== 32'h0) begin
         errors++;
         $display("FAIL rst_over_write got %h nb %h want 0", rd_data0, nb_data1);
      end
      rd_addr0 = 5'd5; rd_addr1 = 5'd7;
      #1;
      tests++;
      if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
         errors++;
         $display("FAIL rst_clears_all got x5=%h x7=%h want 0", rd_data0, rd_data1);
      end
   endtask

   task automatic test_alu_add();
      write(5'd31, 32'h80000000);
      write(5'd1, 32'h00000001);
      rd_addr0 = 5'd31; rd_addr1 = 5'd1;
      #1;
      tests++;
      if (rd_data0 !== 32'h80000000 || rd_data1 !== 32'h00000001) begin
         errors++;
         $display("FAIL alu_operands got %h/%h want 80000000/00000001", rd_data0, rd_data1);
      end
      tests++;
      if (rd_data0 + rd_data1 !== 32'h80000001) begin
         errors++;
         $display("FAIL alu_add got %h want 80000001", rd_data0 + rd_data1);
      end
   endtask

   task automatic test_back_to_back();
      wr_ena = 1'b1;
      for (int i = 10; i < 14; i++) begin
         wr_addr = 5'(i); wr_data = 32'hC0DE0000 | 32'(i);
         tick();
      end
      wr_addr = 5'd10; wr_data = 32'h0BADF00D;
      tick();
      wr_ena = 1'b0;
      rd_addr0 = 5'd10; rd_addr1 = 5'd13;
      #1;
      tests++;
      if (rd_data0 !== 32'h0BADF00D || rd_data1 !== 32'hC0DE000D) begin
         errors++;
         $display("FAIL b2b_10_13 got %h/%h want 0badf00d/c0de000d", rd_data0, rd_data1);
      end
      rd_addr0 = 5'd11; rd_addr1 = 5'd12;
      #1;
      tests++;
      if (rd_data0 !== 32'hC0DE000B || nb_data1 !== 32'hC0DE000C) begin
         errors++;
         $display("FAIL b2b_11_12 got %h nb %h want c0de000b/c0de000c", rd_data0, nb_data1);
      end
      rd_addr0 = 5'd14;
      #1;
      tests++;
      if (rd_data0 !== 32'h0) begin
         errors++;
         $display("FAIL b2b_x14_untouched got %h want 0", rd_data0);
      end
   endtask

   initial begin
      tick();
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_reset_priority();
      test_alu_add();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
